aes192_dec_key_schedule: RTL and testbench
==========================================

Name: aes192_dec_key_schedule

Overview:
- Sequential AES-192 key-schedule engine that sits directly upstream of the combinational AES-192 decryption datapath.
- Accepts one 192-bit cipher key and iterates the 192-bit key-expansion step once per clock, 8 steps in all.
- Stores the 9 expanded 192-bit key blocks (ke0..ke8).
- Serves the 13 round keys (128 bits each) in decryption order through a registered, indexed read port.

Parameters:
- NR, 12, number of AES-192 rounds; round-key indices run 0..NR.
- NSTEP, 8, number of expansion steps; key blocks stored are NSTEP+1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- key_valid  input  1  key_in is valid this cycle
- key_ready  output  1  block can accept a new key
- key_in  input  192  cipher key, word w0 in [191:160]
- keys_ready  output  1  all 13 round keys are valid
- rd_idx  input  4  decryption round index, 0..12
- rd_key  output  128  round key for rd_idx, registered
- rd_valid  output  1  rd_key is valid for the index presented on the previous cycle

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, step counter=0, rcon=32'h01000000.
  - All ke registers=0, keys_ready=0, rd_key=0, rd_valid=0.
  - key_ready=1 once rst deasserts.
- key_ready is combinational: 1 in IDLE and DONE, 0 in EXPAND.
- Key acceptance:
  - Occurs on a clk edge where key_valid & key_ready are both 1.
  - On that edge: ke0<=key_in, cnt<=0, rcon<=32'h01000000, keys_ready<=0, state<=EXPAND.
- EXPAND:
  - Each edge: ke[cnt+1] <= step(ke[cnt], rcon); rcon <= rcon<<1; cnt<=cnt+1.
  - Edge with cnt==7 writes ke8 and moves to DONE.
  - keys_ready<=1 on that same edge, i.e. 8 edges after the acceptance edge.
  - key_valid is ignored in EXPAND.
- DONE:
  - Holds all keys; keys_ready stays 1.
  - A new accepted key restarts EXPAND and drops keys_ready on the acceptance edge.
- Step function (words w0..w5 of the input block, w0 MSB):
  - t = SubWord(RotWord(w5)) ^ rcon.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2, n4=w4^n3, n5=w5^n4.
  - Output block = {n0..n5}.
- Round-key mapping:
  - Concatenated word stream W = ke0 words, then ke1 words, ... then ke8 words (54 words; last two unused).
  - Encryption key j = W[4j..4j+3].
  - Decryption index r returns encryption key 12-r.
  - Resulting map: r0=ke8[191:64], r1=ke7[127:0], r2={ke6[63:0],ke7[191:128]}, r3=ke6[191:64], and the same 3-period pattern continues down to r12=ke0[191:64].
- Read port:
  - Every edge: rd_key<=map(rd_idx), rd_valid<=keys_ready & (rd_idx<=12).
  - rd_idx 13..15: rd_key<=0, rd_valid<=0.
  - Reads while keys_ready=0 return current register contents with rd_valid=0.
- Simultaneous events:
  - New key accepted in DONE while a read is presented: the read samples pre-edge contents with rd_valid=1.
  - The next cycle shows rd_valid=0.
- Reset mid-EXPAND aborts immediately and clears everything to reset values.

Decomposition:
- Shared package aes_pkg holds:
  - the S-box function/table;
  - RCON constants;
  - NR192=12 and NSTEP192=8;
  - 32-bit word typedef.
- One sub-module aes192_key_step: combinational 192-bit step(key_in, rcon) -> key_out, using the aes_pkg S-box.
- The top level holds the FSM, counter, rcon register, ke bank and read mux.

Test Plan:
- Reset: assert rst mid-idle -> keys_ready=0, rd_valid=0, rd_key=0, key_ready=1 after release.
- Load FIPS-197 key 000102…1617 -> keys_ready rises exactly 8 edges after acceptance. Then:
  - rd_idx=12 -> 000102030405060708090a0b0c0d0e0f;
  - rd_idx=11 -> 10111213141516175846f2f95c43f4fe;
  - rd_idx=0 -> a4970a331a78dc09c418c271e3a41d5d;
  - each with rd_valid=1 one cycle after the index.
- Load key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> ke1 word0 = fe0c91f7. Sweep rd_idx 0..12 and compare against a reference model.
- key_valid pulsed during EXPAND with a different key -> ignored; results equal those of the first key.
- rd_idx=13 and 15 with keys_ready=1 -> rd_valid=0, rd_key=0.
- Reload in DONE:
  - keys_ready drops on the acceptance edge;
  - rst asserted at step 4 of a subsequent load -> all outputs return to reset values asynchronously;
  - a fresh load then completes correctly.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, S-box, round constants and AES-192 sizing.
package aes_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      DONE   = 2'd2
   } ks_state_t;

   localparam int NR192    = 12;
   localparam int NSTEP192 = 8;

   // Round constant used by the first expansion step; later steps shift it left.
   localparam word_t RCON_INIT = 32'h01000000;

   // Forward S-box; entry 0 sits in the most significant byte.
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Byte-wise substitution of a 32-bit word.
   function automatic word_t sub_word(input word_t w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

endpackage

// File: rtl/aes192_dec_key_schedule_if.sv
// Key load and round-key read bus of the AES-192 decryption key schedule.
interface aes192_dec_key_schedule_if;

   logic         key_valid;
   logic         key_ready;
   logic [191:0] key_in;
   logic         keys_ready;
   logic [3:0]   rd_idx;
   logic [127:0] rd_key;
   logic         rd_valid;

   modport master (
      output key_valid, key_in, rd_idx,
      input  key_ready, keys_ready, rd_key, rd_valid
   );

   modport slave (
      input  key_valid, key_in, rd_idx,
      output key_ready, keys_ready, rd_key, rd_valid
   );

endinterface

// File: rtl/aes192_key_step.sv
// One AES-192 key-expansion step: six new words from the previous six.
module aes192_key_step
   import aes_pkg::*;
(
   input  logic [191:0] key_in,
   input  word_t        rcon,
   output logic [191:0] key_out
);

   word_t w0, w1, w2, w3, w4, w5;
   word_t t;
   word_t n0, n1, n2, n3, n4, n5;

   assign {w0, w1, w2, w3, w4, w5} = key_in;

   // RotWord moves the top byte to the bottom before substitution.
   assign t = sub_word({w5[23:0], w5[31:24]}) ^ rcon;

   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;
   assign n4 = w4 ^ n3;
   assign n5 = w5 ^ n4;

   assign key_out = {n0, n1, n2, n3, n4, n5};

endmodule

// File: rtl/aes192_dec_key_schedule.sv
// AES-192 key schedule: expands one key over eight cycles and serves the
// thirteen round keys in decryption order through a registered read port.
module aes192_dec_key_schedule
   import aes_pkg::*;
(
   input logic                      clk,
   input logic                      rst,
   aes192_dec_key_schedule_if.slave bus
);

   localparam int NR    = NR192;
   localparam int NSTEP = NSTEP192;

   ks_state_t    state;
   logic [2:0]   cnt;
   word_t        rcon;
   logic [191:0] ke [0:NSTEP];
   logic         keys_ready_r;
   logic [127:0] rd_key_r;
   logic         rd_valid_r;

   logic [3:0]   nxt_idx;
   logic [191:0] step_out;
   logic         accept;
   logic         idx_ok;
   logic [1727:0] w_flat;
   logic [3:0]   enc_idx;
   logic [10:0]  base;
   logic [127:0] map_key;

   assign bus.key_ready  = (state != EXPAND);
   assign bus.keys_ready = keys_ready_r;
   assign bus.rd_key     = rd_key_r;
   assign bus.rd_valid   = rd_valid_r;

   assign accept  = bus.key_valid & bus.key_ready;
   assign nxt_idx = {1'b0, cnt} + 4'd1;
   assign idx_ok  = (bus.rd_idx <= 4'(NR));

   aes192_key_step u_step (
      .key_in  (ke[{1'b0, cnt}]),
      .rcon    (rcon),
      .key_out (step_out)
   );

   // The key blocks concatenated form the encryption word stream W[0..53].
   assign w_flat = {ke[0], ke[1], ke[2], ke[3], ke[4], ke[5], ke[6], ke[7], ke[8]};

   // Decryption index r reads encryption key 12-r, i.e. words 4j..4j+3 of W.
   always_comb begin
      map_key = '0;
      enc_idx = '0;
      base    = '0;
      if (idx_ok) begin
         enc_idx = 4'(NR) - bus.rd_idx;
         base    = 11'd1727 - {enc_idx, 7'd0};
         map_key = w_flat[base -: 128];
      end
   end

   // Control FSM, step counter, round constant and key bank.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         rcon         <= RCON_INIT;
         keys_ready_r <= 1'b0;
         for (int i = 0; i <= NSTEP; i++) begin
            ke[i] <= '0;
         end
      end else begin
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  ke[0]        <= bus.key_in;
                  cnt          <= '0;
                  rcon         <= RCON_INIT;
                  keys_ready_r <= 1'b0;
                  state        <= EXPAND;
               end
            end
            EXPAND: begin
               ke[nxt_idx] <= step_out;
               rcon        <= rcon << 1;
               cnt         <= cnt + 3'd1;
               if (cnt == 3'(NSTEP - 1)) begin
                  state        <= DONE;
                  keys_ready_r <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered read port; validity reflects key readiness before this edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_key_r   <= '0;
         rd_valid_r <= 1'b0;
      end else begin
         rd_key_r   <= map_key;
         rd_valid_r <= keys_ready_r & idx_ok;
      end
   end

endmodule

// File: tb/tb_aes192_dec_key_schedule.sv
// Directed bench for the AES-192 decryption key schedule with an independent
// word-by-word key expansion model built on a computed S-box.
module tb_aes192_dec_key_schedule;

   localparam logic [191:0] K1 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [191:0] K2 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;

   logic clk = 1'b0;
   logic rst;

   aes192_dec_key_schedule_if bus();

   aes192_dec_key_schedule dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0]  sbox_m [0:255];
   logic [31:0] mw     [0:51];

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Hard stop if the run somehow stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed no end, expected finish before timeout");
      $fatal(1, "[TB] timeout");
   end

   task automatic checkOutput(input string tag, input logic [191:0] observed,
                              input logic [191:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic valid, input logic [191:0] key,
                                input logic [3:0] idx);
      bus.key_valid = valid;
      bus.key_in    = key;
      bus.rd_idx    = idx;
      tick();
   endtask

   task automatic loadKey(input logic [191:0] key);
      applyStimulus(1'b1, key, bus.rd_idx);
      bus.key_valid = 1'b0;
   endtask

   task automatic waitReady(output int edges);
      edges = 0;
      while (bus.keys_ready !== 1'b1 && edges < 20) begin
         tick();
         edges++;
      end
   endtask

   task automatic readAndCheck(input logic [3:0] idx, input logic [127:0] expected,
                               input string tag);
      applyStimulus(1'b0, bus.key_in, idx);
      checkOutput(tag, 192'(bus.rd_key), 192'(expected));
      checkOutput({tag, "_valid"}, 192'(bus.rd_valid), 192'(1));
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = '0;
      aa = a;
      bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] v);
      return {v[6:0], v[7]};
   endfunction

   task automatic buildSbox();
      logic [7:0] inv, r1, r2, r3, r4;
      for (int x = 0; x < 256; x++) begin
         inv = '0;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         r1 = rotl1(inv);
         r2 = rotl1(r1);
         r3 = rotl1(r2);
         r4 = rotl1(r3);
         sbox_m[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
      end
   endtask

   task automatic computeModel(input logic [191:0] key);
      logic [31:0] temp;
      logic [7:0]  rc;
      for (int i = 0; i < 6; i++) begin
         mw[i] = key[191 - 32*i -: 32];
      end
      rc = 8'h01;
      for (int i = 6; i < 52; i++) begin
         temp = mw[i-1];
         if (i % 6 == 0) begin
            temp = {temp[23:0], temp[31:24]};
            temp = {sbox_m[temp[31:24]], sbox_m[temp[23:16]],
                    sbox_m[temp[15:8]], sbox_m[temp[7:0]]} ^ {rc, 24'h0};
            rc   = gmul(rc, 8'h02);
         end
         mw[i] = mw[i-6] ^ temp;
      end
   endtask

   function automatic logic [127:0] expKey(input int r);
      int j;
      j = 12 - r;
      return {mw[4*j], mw[4*j+1], mw[4*j+2], mw[4*j+3]};
   endfunction

   initial begin
      int edges;

      buildSbox();
      rst           = 1'b1;
      bus.key_valid = 1'b0;
      bus.key_in    = '0;
      bus.rd_idx    = '0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      tick();

      // Reset asserted while idle
      #2 rst = 1'b1;
      #1;
      checkOutput("rst_keys_ready", 192'(bus.keys_ready), 192'(0));
      checkOutput("rst_rd_valid", 192'(bus.rd_valid), 192'(0));
      checkOutput("rst_rd_key", 192'(bus.rd_key), 192'(0));
      tick();
      rst = 1'b0;
      #1;
      checkOutput("rst_key_ready", 192'(bus.key_ready), 192'(1));
      tick();

      // FIPS-197 AES-192 key
      loadKey(K1);
      checkOutput("k1_key_ready_busy", 192'(bus.key_ready), 192'(0));
      checkOutput("k1_keys_ready_low", 192'(bus.keys_ready), 192'(0));
      waitReady(edges);
      checkOutput("k1_expand_edges", 192'(edges), 192'(8));
      checkOutput("k1_key_ready_done", 192'(bus.key_ready), 192'(1));
      readAndCheck(4'd12, 128'h000102030405060708090a0b0c0d0e0f, "k1_r12");
      readAndCheck(4'd11, 128'h10111213141516175846f2f95c43f4fe, "k1_r11");
      readAndCheck(4'd0,  128'ha4970a331a78dc09c418c271e3a41d5d, "k1_r0");

      // Second key with a stray key_valid pulse during expansion
      loadKey(K2);
      tick();
      tick();
      bus.key_valid = 1'b1;
      bus.key_in    = K1;
      tick();
      bus.key_valid = 1'b0;
      waitReady(edges);
      checkOutput("k2_expand_edges", 192'(edges), 192'(5));
      computeModel(K2);
      for (int r = 0; r <= 12; r++) begin
         readAndCheck(4'(r), expKey(r), $sformatf("k2_r%0d", r));
      end
      applyStimulus(1'b0, bus.key_in, 4'd11);
      checkOutput("k2_ke1_w0", 192'(bus.rd_key[63:32]), 192'(32'hfe0c91f7));

      // Indices beyond the last round
      applyStimulus(1'b0, bus.key_in, 4'd13);
      checkOutput("oob13_key", 192'(bus.rd_key), 192'(0));
      checkOutput("oob13_valid", 192'(bus.rd_valid), 192'(0));
      applyStimulus(1'b0, bus.key_in, 4'd15);
      checkOutput("oob15_key", 192'(bus.rd_key), 192'(0));
      checkOutput("oob15_valid", 192'(bus.rd_valid), 192'(0));

      // Reload in DONE with a read on the same edge
      bus.rd_idx = 4'd0;
      loadKey(K1);
      checkOutput("reload_rd_key", 192'(bus.rd_key), 192'(expKey(0)));
      checkOutput("reload_rd_valid", 192'(bus.rd_valid), 192'(1));
      checkOutput("reload_keys_ready", 192'(bus.keys_ready), 192'(0));
      tick();
      checkOutput("reload_valid_drop", 192'(bus.rd_valid), 192'(0));
      repeat (3) tick();

      // Asynchronous reset in the middle of expansion
      #2 rst = 1'b1;
      #1;
      checkOutput("abort_keys_ready", 192'(bus.keys_ready), 192'(0));
      checkOutput("abort_rd_valid", 192'(bus.rd_valid), 192'(0));
      checkOutput("abort_rd_key", 192'(bus.rd_key), 192'(0));
      checkOutput("abort_key_ready", 192'(bus.key_ready), 192'(1));
      tick();
      rst = 1'b0;
      tick();
      applyStimulus(1'b0, bus.key_in, 4'd0);
      checkOutput("abort_cleared_key", 192'(bus.rd_key), 192'(0));
      checkOutput("abort_cleared_valid", 192'(bus.rd_valid), 192'(0));

      // Fresh load after the abort
      loadKey(K2);
      waitReady(edges);
      checkOutput("fresh_expand_edges", 192'(edges), 192'(8));
      readAndCheck(4'd0,  expKey(0),  "fresh_r0");
      readAndCheck(4'd6,  expKey(6),  "fresh_r6");
      readAndCheck(4'd12, expKey(12), "fresh_r12");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
